// File: rtl/bsg_axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// The state enum, the AXI response codes and the code reported on a response timeout.
package bsg_axil_cmd_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_RESP,
      RESP,
      DRAIN
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Reported when B/R never arrives; it shares the encoding with DECERR.
   localparam logic [1:0] TIMEOUT_CODE = 2'b11;

endpackage

// File: rtl/bsg_axil_cmd_master.sv
// AXI4-Lite initiator. It accepts one read or write command on a valid/ready port,
// issues a single AXI-Lite transaction and returns the result on a valid/yumi port.
// Only one transaction is outstanding at a time.
// Optional build macro BSG_AXIL_CMD_MASTER_TIMEOUT_EN adds a B/R response timeout.
// When the timeout fires, the master reports code 2'b11 and then passes through a DRAIN state.
// Every AXI output is a decode of registered state, so nothing depends combinationally on an AXI input.
module bsg_axil_cmd_master
   import bsg_axil_cmd_master_pkg::*;
#(
   parameter int axil_data_width_p = 32,
   parameter int axil_addr_width_p = 6,
   parameter int timeout_p         = 1024
)(
   input  logic                           aclk,
   input  logic                           areset,

   input  logic                           cmd_v_i,
   output logic                           cmd_ready_o,
   input  logic                           cmd_write_i,
   input  logic [axil_addr_width_p-1:0]   cmd_addr_i,
   input  logic [axil_data_width_p-1:0]   cmd_data_i,
   input  logic [axil_data_width_p/8-1:0] cmd_wstrb_i,

   output logic                           resp_v_o,
   input  logic                           resp_yumi_i,
   output logic                           resp_write_o,
   output logic [axil_data_width_p-1:0]   resp_data_o,
   output logic [1:0]                     resp_code_o,

   output logic [axil_addr_width_p-1:0]   m_axi_awaddr,
   output logic [2:0]                     m_axi_awprot,
   output logic                           m_axi_awvalid,
   input  logic                           m_axi_awready,
   output logic [axil_data_width_p-1:0]   m_axi_wdata,
   output logic [axil_data_width_p/8-1:0] m_axi_wstrb,
   output logic                           m_axi_wvalid,
   input  logic                           m_axi_wready,
   input  logic [1:0]                     m_axi_bresp,
   input  logic                           m_axi_bvalid,
   output logic                           m_axi_bready,
   output logic [axil_addr_width_p-1:0]   m_axi_araddr,
   output logic [2:0]                     m_axi_arprot,
   output logic                           m_axi_arvalid,
   input  logic                           m_axi_arready,
   input  logic [axil_data_width_p-1:0]   m_axi_rdata,
   input  logic [1:0]                     m_axi_rresp,
   input  logic                           m_axi_rvalid,
   output logic                           m_axi_rready
);

   // Elaboration-time parameter legality.
   if (!(axil_data_width_p == 32 || axil_data_width_p == 64)) begin : g_bad_data_width
      $error("axil_data_width_p must be 32 or 64");
   end
   if (timeout_p < 2) begin : g_bad_timeout
      $error("timeout_p must be at least 2");
   end

   state_e                         state_reg, state_next;
   logic [axil_addr_width_p-1:0]   addr_reg;
   logic [axil_data_width_p-1:0]   data_reg;
   logic [axil_data_width_p/8-1:0] wstrb_reg;
   logic                           write_reg;
   logic                           aw_done_reg, w_done_reg;
   logic [axil_data_width_p-1:0]   resp_data_reg;
   logic [1:0]                     resp_code_reg;
   logic                           cmd_fire;

   assign cmd_fire = cmd_v_i & cmd_ready_o;

`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
   localparam int cnt_width_lp = $clog2(timeout_p);
   logic [cnt_width_lp-1:0] cnt_reg;
   logic                    hs_done_reg, taken_reg;
   logic                    timeout_hit, late_hs;

   assign timeout_hit = (((state_reg == WR_RESP) & ~m_axi_bvalid) |
                         ((state_reg == RD_RESP) & ~m_axi_rvalid)) &
                        (cnt_reg == cnt_width_lp'(timeout_p - 1));
   assign late_hs     = write_reg ? m_axi_bvalid : m_axi_rvalid;

   // Wait counter: held at zero until the response phase starts, then counts each waiting cycle.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)
         cnt_reg <= '0;
      else if ((state_reg == WR_RESP) || (state_reg == RD_RESP))
         cnt_reg <= cnt_reg + 1'b1;
      else
         cnt_reg <= '0;
   end

   // Drain bookkeeping: late B/R handshake seen, and timeout response consumed.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         hs_done_reg <= 1'b0;
         taken_reg   <= 1'b0;
      end else if (state_reg != DRAIN) begin
         hs_done_reg <= 1'b0;
         taken_reg   <= 1'b0;
      end else begin
         hs_done_reg <= hs_done_reg | late_hs;
         taken_reg   <= taken_reg | (resp_yumi_i & resp_v_o);
      end
   end
`endif

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:
            if (cmd_fire)
               state_next = cmd_write_i ? WR_ADDR_DATA : RD_ADDR;
         WR_ADDR_DATA:
            if ((aw_done_reg | m_axi_awready) & (w_done_reg | m_axi_wready))
               state_next = WR_RESP;
         WR_RESP:
            if (m_axi_bvalid)
               state_next = RESP;
`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
            else if (timeout_hit)
               state_next = DRAIN;
`endif
         RD_ADDR:
            if (m_axi_arready)
               state_next = RD_RESP;
         RD_RESP:
            if (m_axi_rvalid)
               state_next = RESP;
`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
            else if (timeout_hit)
               state_next = DRAIN;
`endif
         RESP:
            if (resp_yumi_i)
               state_next = IDLE;
`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
         DRAIN:
            if ((hs_done_reg | late_hs) & (taken_reg | resp_yumi_i))
               state_next = IDLE;
`endif
         default:
            state_next = IDLE;
      endcase
   end

   // Latch the accepted command; the payload stays stable for the whole transaction.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         addr_reg  <= '0;
         data_reg  <= '0;
         wstrb_reg <= '0;
         write_reg <= 1'b0;
      end else if (cmd_fire) begin
         addr_reg  <= cmd_addr_i;
         data_reg  <= cmd_data_i;
         wstrb_reg <= cmd_wstrb_i;
         write_reg <= cmd_write_i;
      end
   end

   // Independent AW and W completion flags, so either handshake may finish first.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else if (state_reg != WR_ADDR_DATA) begin
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else begin
         aw_done_reg <= aw_done_reg | m_axi_awready;
         w_done_reg  <= w_done_reg  | m_axi_wready;
      end
   end

   // Capture the response payload from B or R (or the timeout code), then hold it.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         resp_data_reg <= '0;
         resp_code_reg <= OKAY;
      end else if ((state_reg == WR_RESP) && m_axi_bvalid) begin
         resp_data_reg <= '0;
         resp_code_reg <= m_axi_bresp;
      end else if ((state_reg == RD_RESP) && m_axi_rvalid) begin
         resp_data_reg <= m_axi_rdata;
         resp_code_reg <= m_axi_rresp;
      end
`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
      else if (timeout_hit) begin
         resp_data_reg <= '0;
         resp_code_reg <= TIMEOUT_CODE;
      end
`endif
   end

   assign cmd_ready_o   = (state_reg == IDLE);
   assign m_axi_awaddr  = addr_reg;
   assign m_axi_araddr  = addr_reg;
   assign m_axi_wdata   = data_reg;
   assign m_axi_wstrb   = wstrb_reg;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_awvalid = (state_reg == WR_ADDR_DATA) & ~aw_done_reg;
   assign m_axi_wvalid  = (state_reg == WR_ADDR_DATA) & ~w_done_reg;
   assign m_axi_arvalid = (state_reg == RD_ADDR);
`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
   assign m_axi_bready  = (state_reg == WR_RESP) | ((state_reg == DRAIN) &  write_reg);
   assign m_axi_rready  = (state_reg == RD_RESP) | ((state_reg == DRAIN) & ~write_reg);
   assign resp_v_o      = (state_reg == RESP)    | ((state_reg == DRAIN) & ~taken_reg);
`else
   assign m_axi_bready  = (state_reg == WR_RESP);
   assign m_axi_rready  = (state_reg == RD_RESP);
   assign resp_v_o      = (state_reg == RESP);
`endif
   assign resp_write_o  = write_reg;
   assign resp_data_o   = resp_data_reg;
   assign resp_code_o   = resp_code_reg;

endmodule

// File: tb/tb_bsg_axil_cmd_master.sv
// Directed bench for bsg_axil_cmd_master. The AXI slave side is driven by hand from tasks.
// Build with BSG_AXIL_CMD_MASTER_TIMEOUT_EN to add the timeout/drain scenario.
module tb_bsg_axil_cmd_master;

   localparam int DW = 32;
   localparam int AW = 6;

   logic          aclk = 1'b0;
   logic          areset;
   logic          cmd_v_i, cmd_ready_o, cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_data_i;
   logic [DW/8-1:0] cmd_wstrb_i;
   logic          resp_v_o, resp_yumi_i, resp_write_o;
   logic [DW-1:0] resp_data_o;
   logic [1:0]    resp_code_o;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;

   int n_vec = 0;
   int n_err = 0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

   bsg_axil_cmd_master #(
      .axil_data_width_p(DW),
      .axil_addr_width_p(AW),
      .timeout_p(16)
   ) dut (
      .aclk(aclk), .areset(areset),
      .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_wstrb_i(cmd_wstrb_i),
      .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_write_o(resp_write_o),
      .resp_data_o(resp_data_o), .resp_code_o(resp_code_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 aclk = ~aclk;

   // Handshake counters seen at the active edge.
   always @(posedge aclk) begin
      if (m_axi_awvalid & m_axi_awready) aw_hs <= aw_hs + 1;
      if (m_axi_wvalid  & m_axi_wready)  w_hs  <= w_hs  + 1;
      if (m_axi_bvalid  & m_axi_bready)  b_hs  <= b_hs  + 1;
      if (m_axi_arvalid & m_axi_arready) ar_hs <= ar_hs + 1;
      if (m_axi_rvalid  & m_axi_rready)  r_hs  <= r_hs  + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
      check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
      cmd_v_i = 1'b1; cmd_write_i = w; cmd_addr_i = addr;
      cmd_data_i = data; cmd_wstrb_i = strb;
      @(negedge aclk);
      cmd_v_i = 1'b0;
      check("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
      $display("cmd %s addr=%0h data=%0h strb=%0h", w ? "WR" : "RD", addr, data, strb);
   endtask

   task automatic wr_phase(input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                           input logic [DW/8-1:0] es, input int aw_d, input int w_d);
      int aw0 = aw_hs;
      int w0  = w_hs;
      check("awvalid_start", 64'(m_axi_awvalid), 64'd1);
      check("wvalid_start",  64'(m_axi_wvalid),  64'd1);
      check("awprot", 64'(m_axi_awprot), 64'd0);
      for (int c = 0; c < 32; c++) begin
         if (!(m_axi_awvalid | m_axi_wvalid)) break;
         if (m_axi_awvalid) check("awaddr", 64'(m_axi_awaddr), 64'(ea));
         if (m_axi_wvalid) begin
            check("wdata", 64'(m_axi_wdata), 64'(ed));
            check("wstrb", 64'(m_axi_wstrb), 64'(es));
         end
         if (w_d < aw_d && c == w_d + 1) begin
            check("wvalid_dropped", 64'(m_axi_wvalid),  64'd0);
            check("awvalid_held",   64'(m_axi_awvalid), 64'd1);
         end
         m_axi_awready = (c >= aw_d);
         m_axi_wready  = (c >= w_d);
         @(negedge aclk);
      end
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      check("aw_hs_count", 64'(aw_hs - aw0), 64'd1);
      check("w_hs_count",  64'(w_hs - w0),   64'd1);
   endtask

   task automatic b_phase(input logic [1:0] resp, input int dly);
      int b0 = b_hs;
      for (int i = 0; i < dly; i++) begin
         check("bready_wait", 64'(m_axi_bready), 64'd1);
         @(negedge aclk);
      end
      check("bready", 64'(m_axi_bready), 64'd1);
      m_axi_bvalid = 1'b1; m_axi_bresp = resp;
      @(negedge aclk);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      check("b_hs_count", 64'(b_hs - b0), 64'd1);
      check("bready_after", 64'(m_axi_bready), 64'd0);
   endtask

   task automatic rd_phase(input logic [AW-1:0] ea, input int ar_d, input int r_d,
                           input logic [DW-1:0] data, input logic [1:0] resp);
      int ar0 = ar_hs;
      int r0  = r_hs;
      check("arvalid_start", 64'(m_axi_arvalid), 64'd1);
      check("arprot", 64'(m_axi_arprot), 64'd0);
      for (int c = 0; c < 32; c++) begin
         if (!m_axi_arvalid) break;
         check("araddr", 64'(m_axi_araddr), 64'(ea));
         m_axi_arready = (c >= ar_d);
         @(negedge aclk);
      end
      m_axi_arready = 1'b0;
      check("ar_hs_count", 64'(ar_hs - ar0), 64'd1);
      for (int i = 0; i < r_d; i++) begin
         check("rready_wait", 64'(m_axi_rready), 64'd1);
         @(negedge aclk);
      end
      check("rready", 64'(m_axi_rready), 64'd1);
      m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rresp = resp;
      @(negedge aclk);
      m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
      check("r_hs_count", 64'(r_hs - r0), 64'd1);
      check("rready_after", 64'(m_axi_rready), 64'd0);
   endtask

   task automatic take_resp(input logic w, input logic [DW-1:0] data,
                            input logic [1:0] code, input int hold);
      check("resp_v",     64'(resp_v_o),     64'd1);
      check("resp_write", 64'(resp_write_o), 64'(w));
      check("resp_data",  64'(resp_data_o),  64'(data));
      check("resp_code",  64'(resp_code_o),  64'(code));
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         check("hold_resp_v",    64'(resp_v_o),    64'd1);
         check("hold_resp_data", 64'(resp_data_o), 64'(data));
         check("hold_resp_code", 64'(resp_code_o), 64'(code));
         check("hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
      end
      resp_yumi_i = 1'b1;
      @(negedge aclk);
      resp_yumi_i = 1'b0;
      check("resp_v_after_yumi",  64'(resp_v_o),    64'd0);
      check("cmd_ready_after",    64'(cmd_ready_o), 64'd1);
      $display("resp %s data=%0h code=%0h", w ? "WR" : "RD", resp_data_o, resp_code_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      cmd_v_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0; cmd_wstrb_i = '0;
      resp_yumi_i = 1'b0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
      repeat (3) @(negedge aclk);

      // Reset state
      check("rst_cmd_ready", 64'(cmd_ready_o),   64'd1);
      check("rst_awvalid",   64'(m_axi_awvalid), 64'd0);
      check("rst_wvalid",    64'(m_axi_wvalid),  64'd0);
      check("rst_arvalid",   64'(m_axi_arvalid), 64'd0);
      check("rst_bready",    64'(m_axi_bready),  64'd0);
      check("rst_rready",    64'(m_axi_rready),  64'd0);
      check("rst_resp_v",    64'(resp_v_o),      64'd0);
      check("rst_resp_data", 64'(resp_data_o),   64'd0);
      check("rst_resp_code", 64'(resp_code_o),   64'd0);
      areset = 1'b0;
      @(negedge aclk);

      // Write, awready before wready, OKAY
      send_cmd(1'b1, 6'h10, 32'hDEADBEEF, 4'hF);
      wr_phase(6'h10, 32'hDEADBEEF, 4'hF, 0, 1);
      b_phase(2'b00, 0);
      take_resp(1'b1, 32'h0, 2'b00, 0);

      // Read with SLVERR
      send_cmd(1'b0, 6'h20, 32'h0, 4'h0);
      rd_phase(6'h20, 1, 1, 32'h12345678, 2'b10);
      take_resp(1'b0, 32'h12345678, 2'b10, 0);

      // Write, wready three cycles ahead of awready, EXOKAY
      send_cmd(1'b1, 6'h04, 32'hA5A50001, 4'h3);
      wr_phase(6'h04, 32'hA5A50001, 4'h3, 3, 0);
      b_phase(2'b01, 2);
      take_resp(1'b1, 32'h0, 2'b01, 0);

      // Write, same-cycle aw/w readiness, then response held 10 cycles with a read pending
      send_cmd(1'b1, 6'h08, 32'h0BADF00D, 4'hC);
      wr_phase(6'h08, 32'h0BADF00D, 4'hC, 0, 0);
      b_phase(2'b00, 0);
      cmd_v_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 6'h24;
      take_resp(1'b1, 32'h0, 2'b00, 10);
      @(negedge aclk);
      cmd_v_i = 1'b0;
      check("pending_cmd_taken", 64'(cmd_ready_o), 64'd0);
      rd_phase(6'h24, 0, 2, 32'hCAFEF00D, 2'b00);
      take_resp(1'b0, 32'hCAFEF00D, 2'b00, 0);

      // Reset asserted while waiting in WR_RESP
      send_cmd(1'b1, 6'h30, 32'h11223344, 4'hF);
      wr_phase(6'h30, 32'h11223344, 4'hF, 0, 0);
      check("pre_rst_bready", 64'(m_axi_bready), 64'd1);
      areset = 1'b1;
      #1;
      check("midrst_bready",    64'(m_axi_bready),  64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready_o),   64'd1);
      @(negedge aclk);
      areset = 1'b0;
      check("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
      check("midrst_wvalid",  64'(m_axi_wvalid),  64'd0);
      check("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("midrst_resp_v",  64'(resp_v_o),      64'd0);
      @(negedge aclk);
      check("postrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("postrst_bready",    64'(m_axi_bready), 64'd0);

`ifdef BSG_AXIL_CMD_MASTER_TIMEOUT_EN
      // Timeout with timeout_p = 16, bvalid withheld 40 cycles
      begin
         int b0;
         send_cmd(1'b1, 6'h3C, 32'h55AA55AA, 4'hF);
         wr_phase(6'h3C, 32'h55AA55AA, 4'hF, 1, 2);
         b0 = b_hs;
         for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 15) check("to_wait_resp_v", 64'(resp_v_o), 64'd0);
            @(negedge aclk);
         end
         check("to_resp_v",     64'(resp_v_o),     64'd1);
         check("to_resp_code",  64'(resp_code_o),  64'd3);
         check("to_resp_data",  64'(resp_data_o),  64'd0);
         check("to_resp_write", 64'(resp_write_o), 64'd1);
         check("to_cmd_ready",  64'(cmd_ready_o),  64'd0);
         check("to_bready",     64'(m_axi_bready), 64'd1);
         resp_yumi_i = 1'b1;
         @(negedge aclk);
         resp_yumi_i = 1'b0;
         check("drain_resp_v",    64'(resp_v_o),     64'd0);
         check("drain_cmd_ready", 64'(cmd_ready_o),  64'd0);
         check("drain_bready",    64'(m_axi_bready), 64'd1);
         repeat (23) @(negedge aclk);
         check("drain_cmd_ready_late", 64'(cmd_ready_o), 64'd0);
         m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
         @(negedge aclk);
         m_axi_bvalid = 1'b0;
         check("drain_b_hs",       64'(b_hs - b0),    64'd1);
         check("drain_exit_ready", 64'(cmd_ready_o),  64'd1);
         check("drain_exit_bready",64'(m_axi_bready), 64'd0);
         check("drain_code_kept",  64'(resp_code_o),  64'd3);
         $display("resp WR timeout code=%0h", resp_code_o);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
